// File: rtl/maple_in.sv
// -----------------------------------------------------------------------------
// maple_in -- Maple bus receiver.
//
// Samples the bus pins (pin1 = SDCKA, pin5 = SDCKB) through two-flop
// synchronisers and detects edges against a previous-sample register. A frame
// FSM recognises START (pin1 low with four pin5 pulses) and decodes the
// alternating-phase data bits MSB-first into bytes. Each byte goes to the read
// FIFO. The FSM then recognises END and reports frame status through sticky
// flags.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   in_p1, in_p5   raw asynchronous pin levels
//   tx_active      own transmitter is driving the bus
//   trigger_arm    pulse: clear sticky flags and hunt for a frame
//   trigger_abort  pulse: return to DISARMED, flags kept
//   fifo_data/_produce/_ready   byte write interface to the read FIFO
//   armed, in_frame            FSM status
//   end_seen, framing_err, timeout_err, overrun   sticky status flags
// -----------------------------------------------------------------------------
module maple_in #(
    parameter logic [15:0] TIMEOUT = 16'd5000  // must be >= 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_p1,
    input  logic       in_p5,
    input  logic       tx_active,
    input  logic       trigger_arm,
    input  logic       trigger_abort,
    output logic [7:0] fifo_data,
    output logic       fifo_produce,
    input  logic       fifo_ready,
    output logic       armed,
    output logic       in_frame,
    output logic       end_seen,
    output logic       framing_err,
    output logic       timeout_err,
    output logic       overrun
);

    typedef enum logic [2:0] {
        S_DISARMED   = 3'd0,
        S_WAIT_IDLE  = 3'd1,
        S_WAIT_START = 3'd2,
        S_START_CNT  = 3'd3,
        S_PHASE_A    = 3'd4,
        S_PHASE_B    = 3'd5,
        S_END_WAIT   = 3'd6
    } state_t;

    // States reported through in_frame (START has been fully recognised).
    function automatic logic in_frame_f(input state_t s);
        case (s)
            S_PHASE_A, S_PHASE_B, S_END_WAIT: in_frame_f = 1'b1;
            default:                          in_frame_f = 1'b0;
        endcase
    endfunction

    // States in which the bus must keep moving; the inactivity timer runs here.
    function automatic logic tmo_state_f(input state_t s);
        case (s)
            S_START_CNT, S_PHASE_A, S_PHASE_B, S_END_WAIT: tmo_state_f = 1'b1;
            default:                                       tmo_state_f = 1'b0;
        endcase
    endfunction

    // Synchroniser and edge-detect registers
    logic p1_meta_q, p1_sync_q, p1_prev_q;
    logic p5_meta_q, p5_sync_q, p5_prev_q;

    // Frame state and datapath
    state_t      state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  pulse_cnt_q, pulse_cnt_d;
    logic        pend_q, pend_d;
    logic [15:0] tmo_q, tmo_d;

    // Registered outputs
    logic [7:0]  fifo_data_q, fifo_data_d;
    logic        produce_q, produce_d;
    logic        end_seen_q, end_seen_d;
    logic        framing_err_q, framing_err_d;
    logic        timeout_err_q, timeout_err_d;
    logic        overrun_q, overrun_d;
    logic        armed_q;
    logic        in_frame_q;

    // Decoded edges and helpers
    logic       p1_rise_s, p1_fall_s, p5_rise_s, p5_fall_s;
    logic       p1_edge_s, p5_edge_s, any_edge_s, both_edge_s;
    logic       tmo_expired_s;
    logic [7:0] byte_s;
    logic [2:0] bit_sum_s;

    // Two-flop synchronisers plus previous sample; reset to idle-high bus level
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_meta_q <= 1'b1;
            p1_sync_q <= 1'b1;
            p1_prev_q <= 1'b1;
            p5_meta_q <= 1'b1;
            p5_sync_q <= 1'b1;
            p5_prev_q <= 1'b1;
        end else begin
            p1_meta_q <= in_p1;
            p1_sync_q <= p1_meta_q;
            p1_prev_q <= p1_sync_q;
            p5_meta_q <= in_p5;
            p5_sync_q <= p5_meta_q;
            p5_prev_q <= p5_sync_q;
        end
    end

    assign p1_rise_s   = p1_sync_q & ~p1_prev_q;
    assign p1_fall_s   = ~p1_sync_q & p1_prev_q;
    assign p5_rise_s   = p5_sync_q & ~p5_prev_q;
    assign p5_fall_s   = ~p5_sync_q & p5_prev_q;
    assign p1_edge_s   = p1_rise_s | p1_fall_s;
    assign p5_edge_s   = p5_rise_s | p5_fall_s;
    assign any_edge_s  = p1_edge_s | p5_edge_s;
    assign both_edge_s = p1_edge_s & p5_edge_s;

    // A phase-B commit shifts in the pending phase-A bit followed by pin1.
    assign byte_s    = {shift_q[5:0], pend_q, p1_sync_q};
    assign bit_sum_s = bit_cnt_q + 3'd2;

    // The timer holds TIMEOUT-1 after that many quiet cycles; one more expires it.
    assign tmo_expired_s = ~any_edge_s && (tmo_q == (TIMEOUT - 16'd1));

    // Frame FSM next-state, byte assembly and sticky flag updates
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        pulse_cnt_d   = pulse_cnt_q;
        pend_d        = pend_q;
        fifo_data_d   = fifo_data_q;
        produce_d     = 1'b0;
        end_seen_d    = end_seen_q;
        framing_err_d = framing_err_q;
        timeout_err_d = timeout_err_q;
        overrun_d     = overrun_q;

        if (trigger_abort) begin
            state_d = S_DISARMED;
        end else if (trigger_arm) begin
            state_d       = S_WAIT_IDLE;
            end_seen_d    = 1'b0;
            framing_err_d = 1'b0;
            timeout_err_d = 1'b0;
            overrun_d     = 1'b0;
        end else begin
            case (state_q)
                S_DISARMED: begin
                    state_d = S_DISARMED;
                end

                S_WAIT_IDLE: begin
                    if (!tx_active && p1_sync_q && p5_sync_q) begin
                        state_d = S_WAIT_START;
                    end else begin
                        state_d = S_WAIT_IDLE;
                    end
                end

                S_WAIT_START: begin
                    if (p1_fall_s && p5_sync_q) begin
                        state_d     = S_START_CNT;
                        pulse_cnt_d = 3'd0;
                    end else if (any_edge_s) begin
                        state_d = S_WAIT_IDLE;
                    end else begin
                        state_d = S_WAIT_START;
                    end
                end

                S_START_CNT: begin
                    if (tx_active) begin
                        framing_err_d = 1'b1;
                        state_d       = S_WAIT_IDLE;
                    end else if (p1_rise_s) begin
                        if (pulse_cnt_q == 3'd4) begin
                            state_d   = S_PHASE_A;
                            bit_cnt_d = 3'd0;
                            shift_d   = 8'd0;
                        end else begin
                            framing_err_d = 1'b1;
                            state_d       = S_WAIT_IDLE;
                        end
                    end else if (p5_fall_s && !p1_sync_q) begin
                        // Saturate so a long pulse train cannot alias back to 4.
                        if (pulse_cnt_q != 3'd7) begin
                            pulse_cnt_d = pulse_cnt_q + 3'd1;
                        end else begin
                            pulse_cnt_d = pulse_cnt_q;
                        end
                    end else if (tmo_expired_s) begin
                        timeout_err_d = 1'b1;
                        state_d       = S_WAIT_IDLE;
                    end else begin
                        state_d = S_START_CNT;
                    end
                end

                S_PHASE_A: begin
                    if (tx_active || both_edge_s) begin
                        framing_err_d = 1'b1;
                        state_d       = S_WAIT_IDLE;
                    end else if (p1_fall_s) begin
                        // Held until phase B decides between data and END.
                        pend_d  = p5_sync_q;
                        state_d = S_PHASE_B;
                    end else if (tmo_expired_s) begin
                        timeout_err_d = 1'b1;
                        state_d       = S_WAIT_IDLE;
                    end else begin
                        state_d = S_PHASE_A;
                    end
                end

                S_PHASE_B: begin
                    if (tx_active || both_edge_s) begin
                        framing_err_d = 1'b1;
                        state_d       = S_WAIT_IDLE;
                    end else if (p5_fall_s) begin
                        shift_d   = byte_s;
                        bit_cnt_d = bit_sum_s;
                        state_d   = S_PHASE_A;
                        if (bit_sum_s == 3'd0) begin
                            if (fifo_ready) begin
                                fifo_data_d = byte_s;
                                produce_d   = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end else begin
                            produce_d = 1'b0;
                        end
                    end else if (p1_fall_s && !p5_sync_q) begin
                        // END marker: the pending bit is not data.
                        if (bit_cnt_q == 3'd0) begin
                            state_d = S_END_WAIT;
                        end else begin
                            framing_err_d = 1'b1;
                            state_d       = S_WAIT_IDLE;
                        end
                    end else if (tmo_expired_s) begin
                        timeout_err_d = 1'b1;
                        state_d       = S_WAIT_IDLE;
                    end else begin
                        state_d = S_PHASE_B;
                    end
                end

                S_END_WAIT: begin
                    if (tx_active) begin
                        framing_err_d = 1'b1;
                        state_d       = S_WAIT_IDLE;
                    end else if (p5_rise_s) begin
                        end_seen_d = 1'b1;
                        state_d    = S_DISARMED;
                    end else if (tmo_expired_s) begin
                        timeout_err_d = 1'b1;
                        state_d       = S_WAIT_IDLE;
                    end else begin
                        state_d = S_END_WAIT;
                    end
                end

                default: begin
                    state_d = S_DISARMED;
                end
            endcase
        end
    end

    // Inactivity timer: restarts on any edge or state change, runs only mid-frame
    always_comb begin
        if (tmo_state_f(state_q) && (state_d == state_q) && !any_edge_s) begin
            tmo_d = tmo_q + 16'd1;
        end else begin
            tmo_d = 16'd0;
        end
    end

    // State, datapath and registered output update
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_DISARMED;
            shift_q       <= 8'd0;
            bit_cnt_q     <= 3'd0;
            pulse_cnt_q   <= 3'd0;
            pend_q        <= 1'b0;
            tmo_q         <= 16'd0;
            fifo_data_q   <= 8'd0;
            produce_q     <= 1'b0;
            end_seen_q    <= 1'b0;
            framing_err_q <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_q     <= 1'b0;
            armed_q       <= 1'b0;
            in_frame_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            pulse_cnt_q   <= pulse_cnt_d;
            pend_q        <= pend_d;
            tmo_q         <= tmo_d;
            fifo_data_q   <= fifo_data_d;
            produce_q     <= produce_d;
            end_seen_q    <= end_seen_d;
            framing_err_q <= framing_err_d;
            timeout_err_q <= timeout_err_d;
            overrun_q     <= overrun_d;
            armed_q       <= (state_d != S_DISARMED);
            in_frame_q    <= in_frame_f(state_d);
        end
    end

    assign fifo_data    = fifo_data_q;
    assign fifo_produce = produce_q;
    assign armed        = armed_q;
    assign in_frame     = in_frame_q;
    assign end_seen     = end_seen_q;
    assign framing_err  = framing_err_q;
    assign timeout_err  = timeout_err_q;
    assign overrun      = overrun_q;

endmodule
